// File: rtl/sha_seq_pkg.sv
// Shared definitions for the SHA round sequencer.
// Holds the sequencer state encoding and the default geometry constants
// (rounds per block, message-window depth, maximum blocks per run).
package sha_seq_pkg;

  localparam int DEF_NUM_ROUNDS = 64;
  localparam int DEF_WINDOW     = 16;
  localparam int DEF_MAX_BLOCKS = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/sha_mod_counter.sv
// Modulo-MODULUS up counter with synchronous clear and enable.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   clear          - forces the count to zero (wins over enable)
//   enable         - advance by one, wrapping MODULUS-1 -> 0
//   count          - current count value
//   terminal       - high while count == MODULUS-1
module sha_mod_counter #(
  parameter int MODULUS = 64,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_r;

  assign terminal = (count_r == WIDTH'(MODULUS - 1));
  assign count    = count_r;

  // Count register: reset/clear to zero, otherwise advance modulo MODULUS.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (enable) begin
      if (terminal) begin
        count_r <= {WIDTH{1'b0}};
      end else begin
        count_r <= count_r + WIDTH'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/sha_round_sequencer.sv
// SHA round sequencer: steps round index and block index across a run of
// num_blocks message blocks, presenting per-round window and memory
// addresses with a valid/ready handshake.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   start         - run request, honoured only in IDLE
//   num_blocks    - blocks in the run, latched when start is accepted
//   ready         - consumer accepts the current beat
//   abort         - cancel the run (wins over start and ready)
//   valid, busy   - high exactly while running
//   round         - current round within the block
//   win_addr      - round modulo WINDOW
//   mem_addr      - block_idx*WINDOW + win_addr
//   block_idx     - current block
//   load_phase    - round < WINDOW
//   block_done    - last beat of a block is being accepted (combinational)
//   done          - one-cycle pulse after a completed or rejected run
module sha_round_sequencer
  import sha_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int MAX_BLOCKS = DEF_MAX_BLOCKS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(MAX_BLOCKS):0]          num_blocks,
  input  logic                                 ready,
  input  logic                                 abort,
  output logic                                 valid,
  output logic [$clog2(NUM_ROUNDS)-1:0]        round,
  output logic [$clog2(WINDOW)-1:0]            win_addr,
  output logic [$clog2(MAX_BLOCKS*WINDOW)-1:0] mem_addr,
  output logic [$clog2(MAX_BLOCKS)-1:0]        block_idx,
  output logic                                 load_phase,
  output logic                                 block_done,
  output logic                                 done,
  output logic                                 busy
);

  localparam int R_W  = $clog2(NUM_ROUNDS);
  localparam int W_W  = $clog2(WINDOW);
  localparam int B_W  = $clog2(MAX_BLOCKS);
  localparam int NB_W = B_W + 1;
  localparam int M_W  = $clog2(MAX_BLOCKS * WINDOW);

  // Refuse to build a geometry where rounds do not tile the window evenly.
  generate
    if ((WINDOW < 2) || ((WINDOW & (WINDOW - 1)) != 0) ||
        (NUM_ROUNDS < WINDOW) || ((NUM_ROUNDS % WINDOW) != 0)) begin : g_bad_geometry
      $error("sha_round_sequencer: WINDOW must be a power of two and NUM_ROUNDS a multiple of WINDOW");
    end
  endgenerate

  seq_state_e      state_r;
  seq_state_e      state_nxt_s;
  logic [NB_W-1:0] num_blocks_r;
  logic            done_r;
  logic            done_nxt_s;
  logic            nb_load_s;
  logic            round_clr_s;
  logic            round_en_s;
  logic            blk_clr_s;
  logic            blk_en_s;
  logic [R_W-1:0]  round_s;
  logic            round_tc_s;
  logic [B_W-1:0]  blk_s;
  logic            blk_tc_unused_s;
  logic            accept_s;
  logic            start_ok_s;
  logic            last_block_s;

  // A beat only counts when neither reset nor abort overrides the handshake.
  assign accept_s     = (state_r == ST_RUN) && ready && !abort && !reset;
  assign start_ok_s   = (num_blocks >= NB_W'(1)) && (num_blocks <= NB_W'(MAX_BLOCKS));
  assign last_block_s = ({1'b0, blk_s} == (num_blocks_r - NB_W'(1)));

  sha_mod_counter #(.MODULUS(NUM_ROUNDS), .WIDTH(R_W)) u_round_ctr (
    .clock    (clock),
    .reset    (reset),
    .clear    (round_clr_s),
    .enable   (round_en_s),
    .count    (round_s),
    .terminal (round_tc_s)
  );

  // Block terminal flag is unused: the run ends on the latched count instead.
  sha_mod_counter #(.MODULUS(MAX_BLOCKS), .WIDTH(B_W)) u_block_ctr (
    .clock    (clock),
    .reset    (reset),
    .clear    (blk_clr_s),
    .enable   (blk_en_s),
    .count    (blk_s),
    .terminal (blk_tc_unused_s)
  );

  // Next-state, counter control and done-pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    nb_load_s   = 1'b0;
    round_clr_s = 1'b0;
    round_en_s  = 1'b0;
    blk_clr_s   = 1'b0;
    blk_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          if (start_ok_s) begin
            state_nxt_s = ST_RUN;
            nb_load_s   = 1'b1;
            round_clr_s = 1'b1;
            blk_clr_s   = 1'b1;
          end else begin
            // Out-of-range count: report an empty run straight away.
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          round_clr_s = 1'b1;
          blk_clr_s   = 1'b1;
        end else if (accept_s) begin
          round_en_s = 1'b1;
          if (round_tc_s) begin
            if (last_block_s) begin
              state_nxt_s = ST_IDLE;
              done_nxt_s  = 1'b1;
              blk_clr_s   = 1'b1;
            end else begin
              blk_en_s = 1'b1;
            end
          end else begin
            blk_en_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        round_clr_s = 1'b1;
        blk_clr_s   = 1'b1;
      end
    endcase
  end

  // State, latched block count and done-pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      num_blocks_r <= {NB_W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
      if (nb_load_s) begin
        num_blocks_r <= num_blocks;
      end else begin
        num_blocks_r <= num_blocks_r;
      end
    end
  end

  assign valid      = (state_r == ST_RUN);
  assign busy       = (state_r == ST_RUN);
  assign round      = round_s;
  assign win_addr   = round_s[W_W-1:0];
  assign block_idx  = blk_s;
  assign mem_addr   = (M_W'(blk_s) * M_W'(WINDOW)) + M_W'(round_s[W_W-1:0]);
  assign load_phase = ({1'b0, round_s} < (R_W + 1)'(WINDOW));
  assign block_done = accept_s && round_tc_s;
  assign done       = done_r;

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Directed self-checking bench for sha_round_sequencer (default geometry:
// 64 rounds, window 16, up to 8 blocks). Inputs change on the falling edge
// and outputs are sampled 1 time unit later, so block_done reflects the
// inputs of the current cycle.
module tb_sha_round_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] num_blocks;
  logic       ready;
  logic       abort;
  logic       valid;
  logic [5:0] round;
  logic [3:0] win_addr;
  logic [6:0] mem_addr;
  logic [2:0] block_idx;
  logic       load_phase;
  logic       block_done;
  logic       done;
  logic       busy;

  int checks;
  int failures;

  sha_round_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_blocks (num_blocks),
    .ready      (ready),
    .abort      (abort),
    .valid      (valid),
    .round      (round),
    .win_addr   (win_addr),
    .mem_addr   (mem_addr),
    .block_idx  (block_idx),
    .load_phase (load_phase),
    .block_done (block_done),
    .done       (done),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic [3:0] nb;
    logic       ready;
    logic       abort;
    logic       e_valid;
    int         e_round;
    int         e_blk;
    logic       e_bd;
    logic       e_done;
  } vec_t;

  vec_t vecs[13];

  // Apply one cycle's inputs at the falling edge, then let logic settle.
  task automatic drive(input logic s, input logic [3:0] nb, input logic rdy,
                       input logic ab, input logic rst);
    @(negedge clock);
    start      = s;
    num_blocks = nb;
    ready      = rdy;
    abort      = ab;
    reset      = rst;
    #1;
  endtask

  // Compare every output against values derived from round/block.
  task automatic check_out(input string name, input logic e_valid, input int e_round,
                           input int e_blk, input logic e_bd, input logic e_done);
    logic [29:0] exp_v;
    logic [29:0] act_v;
    int e_win;
    int e_mem;
    e_win = e_round % 16;
    e_mem = e_blk * 16 + e_win;
    exp_v = {e_valid, e_valid, 6'(e_round), 4'(e_win), 7'(e_mem), 3'(e_blk),
             (e_round < 16) ? 1'b1 : 1'b0, e_bd, e_done, 4'b0000};
    act_v = {valid, busy, round, win_addr, mem_addr, block_idx,
             load_phase, block_done, done, 4'b0000};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got valid=%0b busy=%0b round=%0d win=%0d mem=%0d blk=%0d load=%0b bd=%0b done=%0b; expected valid=%0b round=%0d win=%0d mem=%0d blk=%0d load=%0b bd=%0b done=%0b",
               name, valid, busy, round, win_addr, mem_addr, block_idx, load_phase,
               block_done, done, e_valid, e_round, e_win, e_mem, e_blk,
               (e_round < 16), e_bd, e_done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int b;
    int accepts;
    int bd_count;
    logic rdy;

    checks   = 0;
    failures = 0;
    start = 1'b0; num_blocks = 4'd0; ready = 1'b0; abort = 1'b0; reset = 1'b1;

    //           start nb     rdy   abort  valid round blk bd    done
    vecs[0]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0}; // reset state
    vecs[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0}; // start, zero blocks
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1}; // empty-run done
    vecs[3]  = '{1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0}; // start, too many
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1}; // rejected-run done
    vecs[5]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0}; // good start
    vecs[6]  = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0}; // RUN, ready low
    vecs[7]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0}; // held, accept
    vecs[8]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0}; // start ignored
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0}; // hold
    vecs[11] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0}; // abort wins
    vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0}; // idle, no done

    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].nb, vecs[i].ready, vecs[i].abort, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_round,
                vecs[i].e_blk, vecs[i].e_bd, vecs[i].e_done);
    end

    // Single block, ready always high.
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("one_blk_start", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      check_out($sformatf("one_blk_r%0d", i), 1'b1, i, 0, (i == 63), 1'b0);
    end
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("one_blk_done", 1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check_out("one_blk_after", 1'b0, 0, 0, 1'b0, 1'b0);

    // Three blocks, ready alternating; num_blocks input changed mid-run.
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    check_out("three_blk_start", 1'b0, 0, 0, 1'b0, 1'b0);
    r = 0; b = 0; accepts = 0; bd_count = 0;
    for (int cyc = 0; cyc < 400 && accepts < 192; cyc++) begin
      rdy = ((cyc % 2) == 0);
      drive(1'b0, 4'd5, rdy, 1'b0, 1'b0);
      check_out($sformatf("three_blk_c%0d", cyc), 1'b1, r, b, (rdy && r == 63), 1'b0);
      if (block_done) bd_count++;
      if (rdy) begin
        accepts++;
        if (r == 63) begin
          r = 0;
          b++;
        end else begin
          r++;
        end
      end
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_out("three_blk_done", 1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (bd_count != 3 || accepts != 192) begin
      failures++;
      $display("FAIL three_blk_counts: got block_done=%0d accepts=%0d, expected 3 and 192",
               bd_count, accepts);
    end

    // Abort at block 1, round 20, then restart.
    drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    check_out("abort_start", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 84; i++) begin
      drive(1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      check_out($sformatf("abort_beat%0d", i), 1'b1, i % 64, i / 64, ((i % 64) == 63), 1'b0);
    end
    drive(1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    check_out("abort_cycle", 1'b1, 20, 1, 1'b0, 1'b0);
    drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    check_out("abort_idle", 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check_out("abort_nodone", 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check_out("abort_restart", 1'b1, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    check_out("abort_restart_hold", 1'b1, 0, 0, 1'b0, 1'b0);

    // Reset at block 0, round 40 with ready high.
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("rst_start", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      check_out($sformatf("rst_beat%0d", i), 1'b1, i, 0, 1'b0, 1'b0);
    end
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
    check_out("rst_cycle", 1'b1, 40, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("rst_after", 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("rst_nodone", 1'b0, 0, 0, 1'b0, 1'b0);

    // Start held high through a whole run.
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("held_start", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
      check_out($sformatf("held_r%0d", i), 1'b1, i, 0, (i == 63), 1'b0);
    end
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    check_out("held_done", 1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check_out("held_rerun", 1'b1, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    check_out("held_rerun_abort", 1'b1, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check_out("held_final_idle", 1'b0, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
